led_share_sched: RTL and testbench

- Time-shares the single board LED between N_REQ requesters, each supplying an 8-bit on/off blink pattern.
- Owns a free-running prescaler that produces a pattern tick.
- Round-robin arbiter grants the LED to one requester per pattern period.
- Sits between status sources (UART, PLL lock, error flags) and the LED pin. Replaces per-source free-running blink counters.

---
 rtl/led_share_sched.sv | 164 ++++++++++++++++
 tb/tb_led_share_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_share_sched.sv
// Round-robin time-sharing of one LED between N_REQ blink-pattern requesters.
// Optional LED_PWM_DIM_EN adds i_bright dimming of the LED pin.
module led_share_sched #(
   parameter int N_REQ      = 4,
   parameter int PRESCALE_W = 22,
   parameter int MAX_REPEAT = 3
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [8*N_REQ-1:0] i_pattern,
`ifdef LED_PWM_DIM_EN
   input  logic [3:0]         i_bright,
`endif
   output logic [N_REQ-1:0]   o_grant,
   output logic               o_led,
   output logic               o_tick,
   output logic               o_busy
);

   localparam int IW = $clog2(N_REQ);

   typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

   state_t                state, state_nx;
   logic [PRESCALE_W-1:0] presc;
   logic [IW-1:0]         owner, owner_nx;
   logic [IW-1:0]         rr, rr_nx;
   logic [3:0]            rep, rep_nx;
   logic [2:0]            bidx, bidx_nx;
   logic [7:0]            shift, shift_nx;
   logic [7:0]            pat_sel;
   logic                  led_raw, led_nx;
   logic [N_REQ-1:0]      grant_nx;
   logic                  others;

   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
      return (x == IW'(N_REQ-1)) ? '0 : x + 1'b1;
   endfunction

   function automatic logic [IW-1:0] rr_pick(
      input logic [N_REQ-1:0] req,
      input logic [IW-1:0]    start
   );
      logic [IW-1:0] idx;
      logic [IW-1:0] pick;
      logic          found;
      idx   = start;
      pick  = start;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
         idx = nxt(idx);
      end
      return pick;
   endfunction

   // Select the current owner's pattern slice for loading.
   always_comb begin
      pat_sel = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (owner == IW'(k)) pat_sel = i_pattern[8*k +: 8];
      end
   end

   assign others = |(i_req & ~o_grant);

   // Arbitration and pattern playback next-state logic.
   always_comb begin
      state_nx = state;
      owner_nx = owner;
      rr_nx    = rr;
      rep_nx   = rep;
      bidx_nx  = bidx;
      shift_nx = shift;
      led_nx   = led_raw;
      grant_nx = o_grant;
      unique case (state)
         IDLE: begin
            led_nx   = 1'b0;
            grant_nx = '0;
            if (|i_req) begin
               owner_nx = rr_pick(i_req, rr);
               grant_nx = N_REQ'(1) << owner_nx;
               state_nx = LOAD;
            end
         end
         LOAD: begin
            shift_nx = pat_sel;
            bidx_nx  = 3'd0;
            state_nx = PLAY;
         end
         PLAY: begin
            if (o_tick) begin
               if (!i_req[owner]) begin
                  state_nx = IDLE;
                  led_nx   = 1'b0;
                  grant_nx = '0;
                  rr_nx    = nxt(owner);
                  rep_nx   = 4'd0;
               end else begin
                  led_nx   = shift[7];
                  shift_nx = {shift[6:0], shift[7]};
                  bidx_nx  = bidx + 3'd1;
                  if (bidx == 3'd7) begin
                     state_nx = LOAD;
                     if (!others && rep < 4'd15) begin
                        rep_nx = rep + 4'd1;
                     end else if (others &&
                        ({1'b0, rep} + 5'd1) < 5'(MAX_REPEAT)) begin
                        rep_nx = rep + 4'd1;
                     end else begin
                        rr_nx    = nxt(owner);
                        rep_nx   = 4'd0;
                        owner_nx = rr_pick(i_req, nxt(owner));
                        grant_nx = N_REQ'(1) << owner_nx;
                     end
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, prescaler and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= IDLE;
         presc   <= '0;
         o_tick  <= 1'b0;
         owner   <= '0;
         rr      <= '0;
         rep     <= 4'd0;
         bidx    <= 3'd0;
         shift   <= 8'd0;
         led_raw <= 1'b0;
         o_grant <= '0;
      end else begin
         state   <= state_nx;
         presc   <= presc + 1'b1;
         o_tick  <= &presc;
         owner   <= owner_nx;
         rr      <= rr_nx;
         rep     <= rep_nx;
         bidx    <= bidx_nx;
         shift   <= shift_nx;
         led_raw <= led_nx;
         o_grant <= grant_nx;
      end
   end

   assign o_busy = (state != IDLE);

`ifdef LED_PWM_DIM_EN
   assign o_led = led_raw & (presc[3:0] < i_bright);
`else
   assign o_led = led_raw;
`endif

endmodule

// File: tb/tb_led_share_sched.sv
// Self-checking bench for led_share_sched with a behavioural LED-share model.
// Run with PRESCALE_W=4, N_REQ=4, MAX_REPEAT=2.
module tb_led_share_sched;

   localparam int N  = 4;
   localparam int PW = 4;
   localparam int MR = 2;
   localparam int TP = 1 << PW;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic [3:0]  i_req = '0;
   logic [31:0] i_pattern = '0;
`ifdef LED_PWM_DIM_EN
   logic [3:0]  i_bright = 4'd9;
`endif
   logic [3:0]  o_grant;
   logic        o_led, o_tick, o_busy;

   int n_chk  = 0;
   int n_fail = 0;

   led_share_sched #(.N_REQ(N), .PRESCALE_W(PW), .MAX_REPEAT(MR)) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_req(i_req),
      .i_pattern(i_pattern),
`ifdef LED_PWM_DIM_EN
      .i_bright(i_bright),
`endif
      .o_grant(o_grant),
      .o_led(o_led),
      .o_tick(o_tick),
      .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // ---- behavioural model: owner plays bit (7-pos) of its latched pattern
   int         m_cnt;
   int         m_mode;
   int         m_owner, m_rr, m_rep, m_pos;
   logic [7:0] m_pat;
   logic       m_led;

   function automatic int first_from(input logic [3:0] r, input int s);
      for (int i = 0; i < N; i++)
         if (r[(s + i) % N]) return (s + i) % N;
      return -1;
   endfunction

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         m_cnt = 0; m_mode = 0; m_owner = 0; m_rr = 0;
         m_rep = 0; m_pos = 0; m_pat = '0; m_led = 1'b0;
      end else begin
         bit tk;
         bit oth;
         tk = (m_cnt > 0) && (m_cnt % TP == 0);
         if (m_mode == 0) begin
            if (i_req != 0) begin
               m_owner = first_from(i_req, m_rr);
               m_mode  = 1;
            end
         end else if (m_mode == 1) begin
            m_pat  = i_pattern[8*m_owner +: 8];
            m_pos  = 0;
            m_mode = 2;
         end else if (tk) begin
            if (!i_req[m_owner]) begin
               m_mode = 0; m_led = 1'b0;
               m_rr = (m_owner + 1) % N; m_rep = 0;
            end else begin
               m_led = m_pat[7 - m_pos];
               m_pos = m_pos + 1;
               if (m_pos == 8) begin
                  m_pos  = 0;
                  m_mode = 1;
                  oth = (i_req & ~(4'b1 << m_owner)) != 0;
                  if ((!oth && m_rep < 15) || (oth && m_rep + 1 < MR)) begin
                     m_rep = m_rep + 1;
                  end else begin
                     m_rr    = (m_owner + 1) % N;
                     m_rep   = 0;
                     m_owner = first_from(i_req, m_rr);
                  end
               end
            end
         end
         m_cnt = m_cnt + 1;
      end
   end

   // Compare every cycle against the model, away from the active edge.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         logic [3:0] eg;
         logic       el;
         eg = (m_mode == 0) ? 4'b0 : (4'b1 << m_owner);
         el = m_led;
`ifdef LED_PWM_DIM_EN
         el = el & ((m_cnt % 16) < int'(i_bright));
`endif
         chk("m_grant", o_grant, eg);
         chk("m_led", o_led, el);
         chk("m_tick", o_tick, (m_cnt > 0) && (m_cnt % TP == 0));
         chk("m_busy", o_busy, m_mode != 0);
         chk("onehot", $countones(o_grant) <= 1, 1);
      end
   end

   // Async reset between edges, synchronous release on a falling edge.
   task automatic do_reset();
      @(negedge i_clk);
      #2 i_rst = 1'b1;
      #1;
      chk("rst_led", o_led, 0);
      chk("rst_grant", o_grant, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_tick", o_tick, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   // Return at the falling edge just after a tick has been consumed.
   task automatic next_tick();
      int n;
      n = 0;
      while (o_tick !== 1'b1 && n < 40) begin
         @(negedge i_clk);
         n++;
      end
      if (n >= 40) begin
         n_chk++;
         n_fail++;
         $display("FAIL tick_timeout: no tick within 40 cycles");
      end
      @(negedge i_clk);
   endtask

   logic [7:0] seq1 [8];
   logic [3:0] exp_g;

   initial begin
      seq1 = '{1, 0, 1, 1, 0, 0, 0, 0};

      // reset then idle
      #1 i_rst = 1'b1;
      #1;
      chk("init_led", o_led, 0);
      chk("init_grant", o_grant, 0);
      chk("init_busy", o_busy, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge i_clk);
         chk("idle_tick", o_tick, k == 16);
      end
      chk("idle_grant", o_grant, 0);
      chk("idle_busy", o_busy, 0);

      // single requester, long enough to pass the 15-repeat limit
      do_reset();
      i_pattern = 32'h0000_00B0;
      i_req = 4'b0001;
      @(negedge i_clk);
      chk("single_grant", o_grant, 4'b0001);
      chk("single_busy", o_busy, 1);
      for (int i = 0; i < 16; i++) begin
         next_tick();
         chk("single_seq", o_led, seq1[i % 8]);
      end
      for (int i = 0; i < 18 * 8; i++) next_tick();
      chk("single_kept", o_grant, 4'b0001);

      // contention between requesters 0 and 2
      do_reset();
      i_pattern = 32'h003C_00A5;
      i_req = 4'b0101;
      for (int k = 1; k <= 40; k++) begin
         next_tick();
         if (k % 8 == 4) begin
            exp_g = ((k / 8) % 4 < 2) ? 4'b0001 : 4'b0100;
            chk("contend_grant", o_grant, exp_g);
         end
      end

      // mid-pattern drop by requester 1
      do_reset();
      i_pattern = 32'h0000_FF00;
      i_req = 4'b0010;
      for (int k = 0; k < 3; k++) next_tick();
      chk("drop_led_on", o_led, 1);
      i_req = 4'b0000;
      next_tick();
      chk("drop_led", o_led, 0);
      chk("drop_grant", o_grant, 0);
      chk("drop_busy", o_busy, 0);
      i_req = 4'b1111;
      @(negedge i_clk);
      chk("drop_next", o_grant, 4'b0100);

      // async reset in the middle of playback
      i_pattern = 32'hFFFF_FFFF;
      next_tick();
      next_tick();
      chk("ar_led_on", o_led, 1);
      do_reset();
      i_req = 4'b0101;
      @(negedge i_clk);
      chk("ar_fresh", o_grant, 4'b0001);

      // randomized phase checked by the model
      for (int c = 0; c < 3000; c++) begin
         @(negedge i_clk);
         if ($urandom_range(0, 29) == 0) i_req = 4'($urandom);
         if ($urandom_range(0, 49) == 0) i_pattern = $urandom;
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
